// File: rtl/cluster_expander_if.sv
// Frame-in / bitmap-out bundle for cluster_expander. The producer (master) drives the
// frame strobe and the packed cluster pairs; the expander (slave) returns the bitmap and status.
interface cluster_expander_if #(
    parameter int NSTRIPS   = 1536,
    parameter int NCLUSTERS = 8,
    parameter int ADRB      = 11,
    parameter int CNTB      = 3
);
    logic                            start;
    logic [NCLUSTERS*ADRB-1:0]       adr_in;
    logic [NCLUSTERS*CNTB-1:0]       cnt_in;
    logic                            ready;
    logic [NSTRIPS-1:0]              vpfs_out;
    logic                            vpfs_valid;
    logic [$clog2(NCLUSTERS+1)-1:0]  nclusters_out;
    logic                            overflow;

    modport master (
        output start, adr_in, cnt_in,
        input  ready, vpfs_out, vpfs_valid, nclusters_out, overflow
    );

    modport slave (
        input  start, adr_in, cnt_in,
        output ready, vpfs_out, vpfs_valid, nclusters_out, overflow
    );
endinterface

// File: rtl/cluster_expander.sv
// Expands one frame of up to 8 (adr,cnt) cluster pairs back into a 1536-strip hit bitmap,
// decoding one slot per clock4x cycle (slot 0 first); 9-cycle frame period.
module cluster_expander #(
    parameter int NSTRIPS   = 1536,
    parameter int NCLUSTERS = 8,
    parameter int ADRB      = 11,
    parameter int CNTB      = 3
) (
    input  logic               clock4x,
    input  logic               global_reset_n,
    cluster_expander_if.slave  bus
);
    localparam int IDXB = $clog2(NCLUSTERS);
    localparam int NCB  = $clog2(NCLUSTERS + 1);
    localparam int CW   = 1 << CNTB;

    typedef enum logic {IDLE, DECODE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          rst_sync_q;
    logic                rst_n_int;
    logic [IDXB-1:0]     idx_q;
    logic [ADRB-1:0]     adr_q [NCLUSTERS];
    logic [CNTB-1:0]     cnt_q [NCLUSTERS];
    logic [NSTRIPS-1:0]  work_q, vpfs_q;
    logic [NCB-1:0]      count_q, ncl_q;
    logic                valid_q, ovf_q;
    logic                capture, last, slot_ok;
    logic [NSTRIPS-1:0]  slot_bits;

    function automatic logic slot_used(input logic [ADRB-1:0] a);
        return a < ADRB'(NSTRIPS);
    endfunction

    // Run of cnt+1 ones shifted up to adr; anything shifted past the top strip falls off.
    function automatic logic [NSTRIPS-1:0] slot_mask(input logic [ADRB-1:0] a,
                                                     input logic [CNTB-1:0] c);
        logic [NSTRIPS-1:0] m;
        m = '0;
        for (int k = 0; k < CW; k++) m[k] = (k <= int'(c));
        m = m << a;
        if (!slot_used(a)) m = '0;
        return m;
    endfunction

    // Async assert, synchronous release of the internal reset.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) rst_sync_q <= 2'b00;
        else                 rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    capture = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (idx_q == IDXB'(NCLUSTERS - 1)) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign slot_bits = slot_mask(adr_q[idx_q], cnt_q[idx_q]);
    assign slot_ok   = slot_used(adr_q[idx_q]);

    // Frame copy: only meaningful after capture, so it carries no reset.
    always_ff @(posedge clock4x) begin
        if (capture) begin
            for (int i = 0; i < NCLUSTERS; i++) begin
                adr_q[i] <= bus.adr_in[i*ADRB +: ADRB];
                cnt_q[i] <= bus.cnt_in[i*CNTB +: CNTB];
            end
        end
    end

    always_ff @(posedge clock4x or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= IDLE;
            idx_q   <= '0;
            work_q  <= '0;
            count_q <= '0;
            vpfs_q  <= '0;
            ncl_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= last;
            ovf_q   <= (state_q == DECODE) && bus.start;
            if (capture) begin
                idx_q   <= '0;
                work_q  <= '0;
                count_q <= '0;
            end else if (state_q == DECODE) begin
                work_q  <= work_q | slot_bits;
                count_q <= count_q + NCB'(slot_ok);
                idx_q   <= idx_q + IDXB'(1);
                if (last) begin
                    vpfs_q <= work_q | slot_bits;
                    ncl_q  <= count_q + NCB'(slot_ok);
                    idx_q  <= '0;
                end
            end
        end
    end

    assign bus.ready         = (state_q == IDLE);
    assign bus.vpfs_out      = vpfs_q;
    assign bus.vpfs_valid    = valid_q;
    assign bus.nclusters_out = ncl_q;
    assign bus.overflow      = ovf_q;

endmodule

// File: tb/tb_cluster_expander.sv
// Self-checking bench for cluster_expander: directed table, busy/reset sequences and
// random frames against a strip-by-strip reference model.
module tb_cluster_expander;
    localparam int NS = 1536;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cluster_expander_if bus ();

    cluster_expander dut (
        .clock4x       (clk),
        .global_reset_n(rst_n),
        .bus           (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [87:0] adr;
        logic [23:0] cnt;
        int          n;
        int          pop;
        int          lo;
        int          hi;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_map(input string name, input logic [NS-1:0] got, input logic [NS-1:0] req);
        int first;
        n_tests++;
        if (got !== req) begin
            n_fail++;
            first = -1;
            for (int i = NS - 1; i >= 0; i--) if (got[i] !== req[i]) first = i;
            $display("FAIL %s: got %0d bits set, expected %0d bits set, first differing strip %0d",
                     name, $countones(got), $countones(req), first);
        end
    endtask

    // Reference: walk each slot strip by strip, dropping strips past the end.
    function automatic logic [NS-1:0] model_map(input logic [87:0] a, input logic [23:0] c);
        logic [NS-1:0] m;
        int ad, cn;
        m = '0;
        for (int s = 0; s < 8; s++) begin
            ad = int'(a[11*s +: 11]);
            cn = int'(c[3*s +: 3]);
            if (ad < NS)
                for (int k = 0; k <= cn; k++)
                    if (ad + k < NS) m[ad + k] = 1'b1;
        end
        return m;
    endfunction

    function automatic int model_n(input logic [87:0] a);
        int n;
        n = 0;
        for (int s = 0; s < 8; s++) if (int'(a[11*s +: 11]) < NS) n++;
        return n;
    endfunction

    function automatic int lo_bit(input logic [NS-1:0] m);
        for (int i = 0; i < NS; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int hi_bit(input logic [NS-1:0] m);
        for (int i = NS - 1; i >= 0; i--) if (m[i]) return i;
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One frame: start sampled at edge T, valid expected exactly after edge T+8.
    task automatic run_frame(input logic [87:0] a, input logic [23:0] c,
                             output logic [NS-1:0] got, output logic [3:0] gn);
        int early;
        @(negedge clk);
        check("ready_before_start", bus.ready, 1);
        bus.adr_in = a;
        bus.cnt_in = c;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.adr_in = 88'({$urandom(), $urandom(), $urandom()});
        bus.cnt_in = 24'($urandom());
        check("ready_low_in_decode", bus.ready, 0);
        check("valid_low_after_start", bus.vpfs_valid, 0);
        early = 0;
        for (int k = 1; k < 8; k++) begin
            tick();
            if (bus.vpfs_valid) early++;
        end
        check("no_early_valid", early, 0);
        tick();
        check("valid_at_T+8", bus.vpfs_valid, 1);
        got = bus.vpfs_out;
        gn  = bus.nclusters_out;
        check_map("frame_map", got, model_map(a, c));
        check("frame_nclusters", gn, model_n(a));
        check("frame_no_overflow", bus.overflow, 0);
    endtask

    logic [NS-1:0] got;
    logic [3:0]    gn;
    int            cnt_v;
    logic [87:0]   ra;
    logic [23:0]   rc;
    int            r;

    initial begin
        // Directed table: inputs plus independently stated expectations.
        for (int i = 0; i < 7; i++) begin
            tbl[i].adr = {8{11'h7FF}};
            tbl[i].cnt = '0;
        end
        tbl[0].adr[0 +: 11] = 11'd5;    tbl[0].cnt[0 +: 3] = 3'd2;
        tbl[0].n = 1; tbl[0].pop = 3; tbl[0].lo = 5; tbl[0].hi = 7;
        tbl[1].adr[0 +: 11] = 11'd1533; tbl[1].cnt[0 +: 3] = 3'd7;
        tbl[1].adr[11 +: 11] = 11'd0;   tbl[1].cnt[3 +: 3] = 3'd0;
        tbl[1].n = 2; tbl[1].pop = 4; tbl[1].lo = 0; tbl[1].hi = 1535;
        for (int s = 0; s < 8; s++) begin
            tbl[2].adr[11*s +: 11] = 11'(100 + s);
            tbl[2].cnt[3*s +: 3]   = 3'd7;
        end
        tbl[2].n = 8; tbl[2].pop = 15; tbl[2].lo = 100; tbl[2].hi = 114;
        tbl[3].cnt = 24'hFFFFFF;
        tbl[3].n = 0; tbl[3].pop = 0; tbl[3].lo = -1; tbl[3].hi = -1;
        tbl[4].adr[33 +: 11] = 11'd1536; tbl[4].cnt[9 +: 3]  = 3'd5;
        tbl[4].cnt[3 +: 3]   = 3'd7;
        tbl[4].adr[77 +: 11] = 11'd1535; tbl[4].cnt[21 +: 3] = 3'd0;
        tbl[4].n = 1; tbl[4].pop = 1; tbl[4].lo = 1535; tbl[4].hi = 1535;
        tbl[5].adr[22 +: 11] = 11'd10; tbl[5].cnt[6 +: 3]  = 3'd1;
        tbl[5].adr[55 +: 11] = 11'd10; tbl[5].cnt[15 +: 3] = 3'd1;
        tbl[5].n = 2; tbl[5].pop = 2; tbl[5].lo = 10; tbl[5].hi = 11;
        tbl[6].adr[0 +: 11]  = 11'd1528; tbl[6].cnt[0 +: 3]  = 3'd7;
        tbl[6].adr[77 +: 11] = 11'd0;    tbl[6].cnt[21 +: 3] = 3'd7;
        tbl[6].n = 2; tbl[6].pop = 16; tbl[6].lo = 0; tbl[6].hi = 1535;

        bus.start  = 1'b0;
        bus.adr_in = '1;
        bus.cnt_in = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state
        #20;
        check("rst_vpfs_zero", $countones(bus.vpfs_out), 0);
        check("rst_valid", bus.vpfs_valid, 0);
        check("rst_ready", bus.ready, 1);
        check("rst_ncl", bus.nclusters_out, 0);
        check("rst_overflow", bus.overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_v = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.vpfs_valid) cnt_v++;
        end
        check("idle_no_valid", cnt_v, 0);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].adr, tbl[i].cnt, got, gn);
            check($sformatf("tbl%0d_ncl", i), gn, tbl[i].n);
            check($sformatf("tbl%0d_pop", i), $countones(got), tbl[i].pop);
            check($sformatf("tbl%0d_lo", i), lo_bit(got), tbl[i].lo);
            check($sformatf("tbl%0d_hi", i), hi_bit(got), tbl[i].hi);
        end

        // Busy: second start during decode is dropped; back-to-back start at T+9 accepted.
        @(negedge clk);
        bus.adr_in = tbl[0].adr;
        bus.cnt_in = tbl[0].cnt;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        bus.adr_in = tbl[2].adr;
        bus.cnt_in = tbl[2].cnt;
        bus.start  = 1'b1;
        tick();
        check("busy_overflow_pulse", bus.overflow, 1);
        check("busy_ready_low", bus.ready, 0);
        bus.start = 1'b0;
        tick();
        check("busy_overflow_one_cycle", bus.overflow, 0);
        cnt_v = 0;
        tick(); if (bus.vpfs_valid) cnt_v++;
        tick(); if (bus.vpfs_valid) cnt_v++;
        check("busy_no_early_valid", cnt_v, 0);
        bus.adr_in = tbl[1].adr;
        bus.cnt_in = tbl[1].cnt;
        tick();
        check("busy_valid_T+8", bus.vpfs_valid, 1);
        check_map("busy_map_first_frame", bus.vpfs_out, model_map(tbl[0].adr, tbl[0].cnt));
        check("busy_ncl", bus.nclusters_out, 1);
        bus.start = 1'b1;
        tick();
        check("b2b_accepted", bus.ready, 0);
        check("b2b_no_overflow", bus.overflow, 0);
        check("b2b_valid_dropped", bus.vpfs_valid, 0);
        bus.start = 1'b0;
        cnt_v = 0;
        for (int k = 10; k < 17; k++) begin
            tick();
            if (bus.vpfs_valid) cnt_v++;
        end
        check("b2b_no_early_valid", cnt_v, 0);
        tick();
        check("b2b_valid_T+17", bus.vpfs_valid, 1);
        check_map("b2b_map", bus.vpfs_out, model_map(tbl[1].adr, tbl[1].cnt));
        check("b2b_ncl", bus.nclusters_out, 2);

        // Mid-frame reset
        @(negedge clk);
        bus.adr_in = tbl[2].adr;
        bus.cnt_in = tbl[2].cnt;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_vpfs_zero", $countones(bus.vpfs_out), 0);
        check("midrst_ncl_zero", bus.nclusters_out, 0);
        check("midrst_ready", bus.ready, 1);
        check("midrst_valid", bus.vpfs_valid, 0);
        cnt_v = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.vpfs_valid) cnt_v++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.vpfs_valid) cnt_v++;
        end
        check("midrst_no_valid_pulse", cnt_v, 0);
        run_frame(tbl[6].adr, tbl[6].cnt, got, gn);
        check("midrst_next_pop", $countones(got), 16);

        // Random frames, back to back
        for (int f = 0; f < 40; f++) begin
            for (int s = 0; s < 8; s++) begin
                r = int'($urandom_range(0, 7));
                if (r < 2)       ra[11*s +: 11] = 11'($urandom_range(1536, 2047));
                else if (r == 2) ra[11*s +: 11] = 11'($urandom_range(1520, 1535));
                else             ra[11*s +: 11] = 11'($urandom_range(0, 1535));
                rc[3*s +: 3] = 3'($urandom_range(0, 7));
            end
            run_frame(ra, rc, got, gn);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
